exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Parametrised successor to the single-cycle exception handler of the 5-stage MIPS core. It prioritises synchronous exceptions (EX overflow, ID reserved instruction) and NUM_IRQ maskable interrupts.
- Maintains CP0-style EPC/Cause/Status registers and drives stage flushes.
- Redirect handshake to fetch: the vector is held until fetch accepts it.
- ERET support returns to EPC. Sits beside the hazard unit; feeds the IF PC mux.

Parameters:
- XLEN, 32, datapath/PC width.
- NUM_IRQ, 4, external interrupt lines (1..8), mapped to Cause.IP[NUM_IRQ-1:0].
- EXC_VEC, 32'h80000180, general exception vector (overflow, interrupt).
- RI_VEC, 32'h80000000, reserved-instruction vector.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ovf_exc_EX  in  1  arithmetic overflow in EX.
- ri_exc_ID  in  1  undefined instruction in ID.
- eret_ID  in  1  ERET decoded in ID.
- pc_plus_4_EX  in  XLEN  PC+4 of EX instruction.
- pc_plus_4_ID  in  XLEN  PC+4 of ID instruction.
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- status_we  in  1  MTC0 Status write (from WB).
- status_wdata  in  XLEN  write data; only IE=bit0 and IM=bits[8+NUM_IRQ-1:8] are writable.
- flush_IF, flush_ID, flush_EX  out  1 each  squash the stage register.
- redir_valid  out  1  redirect request to fetch.
- redir_addr  out  XLEN  redirect target.
- redir_ready  in  1  fetch accepts redirect this cycle.
- epc, cause, status  out  XLEN each  CP0 register views.
- in_handler  out  1  equals Status.EXL.

Behaviour:
- Reset: state IDLE. epc=0, cause=0, status=0 (IE=0, EXL=0). All flushes=0, redir_valid=0, redir_addr=0.
- FSM states: IDLE, EXC_REDIR, HANDLER, RET_REDIR.
- Event detection is combinational in IDLE and HANDLER.
  - Priority: ovf_exc_EX > ri_exc_ID > interrupt.
  - Interrupt condition: IE=1 && EXL=0 && |(irq & IM).
- Flushes are asserted in the detect cycle:
  - ovf: IF+ID+EX.
  - ri / interrupt / eret: IF+ID.
  - No flush in the redirect states.
- Detect cycle updates, registered at the next edge:
  - ovf: epc = pc_plus_4_EX-8; ExcCode=12.
  - ri: epc = pc_plus_4_ID-4; ExcCode=10.
  - int: epc = pc_plus_4_ID-4; ExcCode=0.
  - ExcCode lives in cause[6:2]; all other cause bits are 0 except IP.
  - EXL<=1, state->EXC_REDIR, redir_addr latched (RI_VEC for ri, else EXC_VEC).
- Nested synchronous exception in HANDLER (EXL=1): cause.ExcCode updated, epc NOT overwritten, redirect taken. Interrupts are never taken in HANDLER.
- EXC_REDIR:
  - redir_valid=1; redir_addr is stable until handshake.
  - redir_valid && redir_ready -> HANDLER at the next edge.
  - New events are ignored while waiting.
- HANDLER: eret_ID (with no same-cycle exception) -> flush IF+ID, redir_addr latched = epc, state->RET_REDIR.
- RET_REDIR: redir_valid=1 until handshake; on handshake EXL<=0, state->IDLE.
- Same-cycle ovf_exc_EX and eret_ID: the exception wins; eret is discarded by the flush.
- eret_ID in IDLE: ignored (no flush, no redirect).
- cause.IP[8+NUM_IRQ-1:8] is registered every cycle from the raw irq, independent of masking and state.
- status_we:
  - Updates IE/IM at the next edge.
  - A write in the same cycle as an EXL transition affects IE/IM only; EXL is owned by the FSM.
- redir_ready with redir_valid=0 has no effect.
- rst asserted mid-redirect or in HANDLER returns everything to reset values at the next edge.
- Address arithmetic is modulo 2^XLEN.

Optional Feature:
- Macro VECTORED_IRQ_EN.
- Defined: interrupt redirect_addr = EXC_VEC + 32'h200 + (k << 5), where k = lowest-index pending unmasked irq. ExcCode stays 0.
- Not defined: all interrupts use EXC_VEC. Synchronous exception vectors are unaffected either way.

Test Plan:
- Reset, then ovf_exc_EX=1 with pc_plus_4_EX=0x0040_0010:
  - flush_IF/ID/EX=1 that cycle.
  - Next cycle: epc=0x0040_0008, cause[6:2]=12, redir_valid=1, redir_addr=0x8000_0180.
  - redir_ready held low 3 cycles: addr stable; on ready, in_handler=1.
- ri_exc_ID and ovf_exc_EX same cycle:
  - Overflow wins: ExcCode=12, flush_EX=1, epc from EX PC.
- status_we with IE=1, IM=0x0F00, then irq=4'b0100 at pc_plus_4_ID=0x100:
  - flush_IF/ID, epc=0xFC, ExcCode=0, cause.IP bit10=1.
  - With VECTORED_IRQ_EN: redir_addr=0x8000_03C0.
- In HANDLER:
  - irq asserted: no action.
  - ri_exc_ID: ExcCode=10, epc unchanged, redir to 0x8000_0000.
- In HANDLER, eret_ID:
  - flush IF/ID, redir_addr=epc.
  - After handshake: in_handler=0, state IDLE, pending irq taken next cycle.
- rst during EXC_REDIR: next cycle redir_valid=0, epc=0, cause=0, status=0.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: CP0-style exception/interrupt controller for the 5-stage core.
// Prioritises EX overflow > ID reserved instruction > maskable interrupt,
// keeps EPC/Cause/Status, squashes pipeline stages in the detect cycle and
// holds a redirect to fetch until it is accepted. ERET returns to EPC.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ovf_exc_EX, ri_exc_ID, eret_ID   exception / return sources
//   pc_plus_4_EX, pc_plus_4_ID       PC+4 of the EX / ID instruction
//   irq[NUM_IRQ]                     level-sensitive interrupt requests
//   status_we, status_wdata          MTC0 Status write (IE, IM writable)
//   flush_IF/ID/EX                   stage squash, valid in the detect cycle
//   redir_valid/addr, redir_ready    redirect handshake to fetch
//   epc, cause, status, in_handler   CP0 register views (in_handler = EXL)
//
// Optional build macro: VECTORED_IRQ_EN -- interrupts vector to
//   EXC_VEC + 0x200 + (k << 5), k = lowest pending unmasked irq.
module exception_ctrl #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NUM_IRQ = 4,
    parameter logic [XLEN-1:0] EXC_VEC = XLEN'(32'h8000_0180),
    parameter logic [XLEN-1:0] RI_VEC  = XLEN'(32'h8000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ovf_exc_EX,
    input  logic               ri_exc_ID,
    input  logic               eret_ID,
    input  logic [XLEN-1:0]    pc_plus_4_EX,
    input  logic [XLEN-1:0]    pc_plus_4_ID,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               status_we,
    input  logic [XLEN-1:0]    status_wdata,
    output logic               flush_IF,
    output logic               flush_ID,
    output logic               flush_EX,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_addr,
    input  logic               redir_ready,
    output logic [XLEN-1:0]    epc,
    output logic [XLEN-1:0]    cause,
    output logic [XLEN-1:0]    status,
    output logic               in_handler
);

    localparam int unsigned IM_LSB  = 8;
    localparam int unsigned IM_MSB  = IM_LSB + NUM_IRQ - 1;
    localparam logic [4:0]  EXC_OVF = 5'd12;
    localparam logic [4:0]  EXC_RI  = 5'd10;
    localparam logic [4:0]  EXC_INT = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXC_REDIR,
        S_HANDLER,
        S_RET_REDIR
    } state_t;

    state_t               state;
    logic [4:0]           exc_code;
    logic [NUM_IRQ-1:0]   ip;
    logic [NUM_IRQ-1:0]   im;
    logic                 ie;
    logic                 exl;

    logic                 detect_en;
    logic                 take_ovf;
    logic                 take_ri;
    logic                 take_int;
    logic                 take_exc;
    logic                 take_eret;
    logic [NUM_IRQ-1:0]   pend;
    logic [XLEN-1:0]      int_vec;
    logic [XLEN-1:0]      exc_vec;
    logic [XLEN-1:0]      epc_next;
    logic [4:0]           code_next;

    // Only IE and IM are writable; the remaining write-data bits are dropped.
    logic                 unused_wdata;
    assign unused_wdata = ^status_wdata;

    assign cause      = XLEN'({ip, 1'b0, exc_code, 2'b00});
    assign status     = XLEN'({im, 6'b0, exl, ie});
    assign in_handler = exl;

    // Event detection and stage flushes for the current cycle.
    always_comb begin
        detect_en = !rst && (state == S_IDLE || state == S_HANDLER);
        pend      = irq & im;
        take_ovf  = detect_en && ovf_exc_EX;
        take_ri   = detect_en && !ovf_exc_EX && ri_exc_ID;
        take_int  = detect_en && (state == S_IDLE) && !ovf_exc_EX && !ri_exc_ID
                    && ie && !exl && (|pend);
        take_eret = detect_en && (state == S_HANDLER) && !ovf_exc_EX && !ri_exc_ID
                    && eret_ID;
        take_exc  = take_ovf || take_ri || take_int;

        flush_IF  = take_exc || take_eret;
        flush_ID  = take_exc || take_eret;
        flush_EX  = take_ovf;
    end

`ifdef VECTORED_IRQ_EN
    logic [2:0] irq_idx;

    // Lowest-index pending unmasked line selects the vector slot.
    always_comb begin
        irq_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                irq_idx = 3'(i);
            end
        end
        int_vec = EXC_VEC + XLEN'(32'h200) + (XLEN'(irq_idx) << 5);
    end
`else
    assign int_vec = EXC_VEC;
`endif

    // Target, EPC candidate and ExcCode for the winning exception.
    always_comb begin
        exc_vec   = int_vec;
        epc_next  = pc_plus_4_ID - XLEN'(4);
        code_next = EXC_INT;
        if (take_ovf) begin
            exc_vec   = EXC_VEC;
            epc_next  = pc_plus_4_EX - XLEN'(8);
            code_next = EXC_OVF;
        end else if (take_ri) begin
            exc_vec   = RI_VEC;
            code_next = EXC_RI;
        end
    end

    // FSM and all CP0 / redirect state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            epc         <= '0;
            exc_code    <= '0;
            ip          <= '0;
            im          <= '0;
            ie          <= 1'b0;
            exl         <= 1'b0;
            redir_valid <= 1'b0;
            redir_addr  <= '0;
        end else begin
            ip <= irq;
            if (status_we) begin
                ie <= status_wdata[0];
                im <= status_wdata[IM_MSB:IM_LSB];
            end

            case (state)
                S_IDLE, S_HANDLER: begin
                    if (take_exc) begin
                        // Nested exceptions keep the original return address.
                        if (!exl) begin
                            epc <= epc_next;
                        end
                        exc_code    <= code_next;
                        exl         <= 1'b1;
                        redir_valid <= 1'b1;
                        redir_addr  <= exc_vec;
                        state       <= S_EXC_REDIR;
                    end else if (take_eret) begin
                        redir_valid <= 1'b1;
                        redir_addr  <= epc;
                        state       <= S_RET_REDIR;
                    end
                end
                S_EXC_REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= S_HANDLER;
                    end
                end
                S_RET_REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        exl         <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed testbench for exception_ctrl (default parameters).
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ovf_exc_EX;
    logic        ri_exc_ID;
    logic        eret_ID;
    logic [31:0] pc_plus_4_EX;
    logic [31:0] pc_plus_4_ID;
    logic [3:0]  irq;
    logic        status_we;
    logic [31:0] status_wdata;
    logic        flush_IF;
    logic        flush_ID;
    logic        flush_EX;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        redir_ready;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] status;
    logic        in_handler;

    int checks   = 0;
    int failures = 0;

    exception_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ovf_exc_EX   (ovf_exc_EX),
        .ri_exc_ID    (ri_exc_ID),
        .eret_ID      (eret_ID),
        .pc_plus_4_EX (pc_plus_4_EX),
        .pc_plus_4_ID (pc_plus_4_ID),
        .irq          (irq),
        .status_we    (status_we),
        .status_wdata (status_wdata),
        .flush_IF     (flush_IF),
        .flush_ID     (flush_ID),
        .flush_EX     (flush_EX),
        .redir_valid  (redir_valid),
        .redir_addr   (redir_addr),
        .redir_ready  (redir_ready),
        .epc          (epc),
        .cause        (cause),
        .status       (status),
        .in_handler   (in_handler)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_int_vec;

    initial begin
`ifdef VECTORED_IRQ_EN
        exp_int_vec = 32'h8000_03C0;
`else
        exp_int_vec = 32'h8000_0180;
`endif
        rst = 1'b1; ovf_exc_EX = 1'b0; ri_exc_ID = 1'b0; eret_ID = 1'b0;
        pc_plus_4_EX = '0; pc_plus_4_ID = '0; irq = '0;
        status_we = 1'b0; status_wdata = '0; redir_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_epc", epc, 32'h0);
        check("rst_cause", cause, 32'h0);
        check("rst_status", status, 32'h0);
        check("rst_redir_valid", 32'(redir_valid), 32'h0);
        check("rst_redir_addr", redir_addr, 32'h0);
        check("rst_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h0);

        // Overflow from IDLE.
        ovf_exc_EX = 1'b1; pc_plus_4_EX = 32'h0040_0010;
        #1;
        check("ovf_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h7);
        step();
        check("ovf_epc", epc, 32'h0040_0008);
        check("ovf_cause", cause, 32'h0000_0030);
        check("ovf_redir_valid", 32'(redir_valid), 32'h1);
        check("ovf_redir_addr", redir_addr, 32'h8000_0180);
        check("ovf_in_handler", 32'(in_handler), 32'h1);
        // Held overflow while waiting must be ignored.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_no_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h0);
            step();
            check("wait_addr_stable", redir_addr, 32'h8000_0180);
            check("wait_valid", 32'(redir_valid), 32'h1);
            check("wait_epc", epc, 32'h0040_0008);
        end
        ovf_exc_EX = 1'b0;
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        check("hs_valid", 32'(redir_valid), 32'h0);
        check("hs_in_handler", 32'(in_handler), 32'h1);

        // In HANDLER: enable IE/IM, then irq must not be taken.
        status_we = 1'b1; status_wdata = 32'h0000_0F01;
        step();
        status_we = 1'b0;
        check("sw_status", status, 32'h0000_0F03);
        irq = 4'b0100;
        #1;
        check("hdl_irq_no_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h0);
        step();
        check("hdl_irq_cause_ip", cause, 32'h0000_0430);
        check("hdl_irq_no_redir", 32'(redir_valid), 32'h0);

        // Nested reserved instruction in HANDLER.
        ri_exc_ID = 1'b1; pc_plus_4_ID = 32'h0000_0200;
        #1;
        check("ri_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h6);
        step();
        ri_exc_ID = 1'b0;
        check("ri_epc_kept", epc, 32'h0040_0008);
        check("ri_cause", cause, 32'h0000_0428);
        check("ri_redir_addr", redir_addr, 32'h8000_0000);
        check("ri_redir_valid", 32'(redir_valid), 32'h1);
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        check("ri_hs_valid", 32'(redir_valid), 32'h0);

        // ERET from HANDLER.
        eret_ID = 1'b1;
        #1;
        check("eret_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h6);
        step();
        eret_ID = 1'b0;
        check("eret_redir_addr", redir_addr, 32'h0040_0008);
        check("eret_redir_valid", 32'(redir_valid), 32'h1);
        pc_plus_4_ID = 32'h0000_0100;
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        check("eret_in_handler", 32'(in_handler), 32'h0);
        check("eret_status", status, 32'h0000_0F01);
        check("eret_valid_low", 32'(redir_valid), 32'h0);

        // Pending irq taken in IDLE.
        #1;
        check("int_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h6);
        step();
        check("int_epc", epc, 32'h0000_00FC);
        check("int_cause", cause, 32'h0000_0400);
        check("int_redir_addr", redir_addr, exp_int_vec);
        check("int_redir_valid", 32'(redir_valid), 32'h1);

        // Reset during EXC_REDIR.
        rst = 1'b1;
        step();
        rst = 1'b0; irq = 4'b0000;
        check("mid_rst_valid", 32'(redir_valid), 32'h0);
        check("mid_rst_epc", epc, 32'h0);
        check("mid_rst_cause", cause, 32'h0);
        check("mid_rst_status", status, 32'h0);

        // ERET in IDLE and a stray ready are ignored.
        eret_ID = 1'b1; redir_ready = 1'b1;
        #1;
        check("idle_eret_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h0);
        step();
        eret_ID = 1'b0; redir_ready = 1'b0;
        check("idle_eret_valid", 32'(redir_valid), 32'h0);
        check("idle_eret_handler", 32'(in_handler), 32'h0);

        // Simultaneous ovf+ri+eret with a Status write on the EXL edge.
        ovf_exc_EX = 1'b1; ri_exc_ID = 1'b1; eret_ID = 1'b1;
        pc_plus_4_EX = 32'h0000_1000; pc_plus_4_ID = 32'h0000_2000;
        status_we = 1'b1; status_wdata = 32'h0000_0001;
        #1;
        check("prio_flush", 32'({flush_IF, flush_ID, flush_EX}), 32'h7);
        step();
        ovf_exc_EX = 1'b0; ri_exc_ID = 1'b0; eret_ID = 1'b0; status_we = 1'b0;
        check("prio_epc", epc, 32'h0000_0FF8);
        check("prio_cause", cause, 32'h0000_0030);
        check("prio_redir_addr", redir_addr, 32'h8000_0180);
        check("prio_status", status, 32'h0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
